// File: rtl/io_port_bridge.sv
// io_port_bridge: host-side end of the CPU byte I/O ports.
//   Input path : host valid/ready -> 8-deep fall-through FIFO -> I, popped by IEnable.
//   Output path: OEnable captures O -> 8-deep FIFO -> host valid/ready.
// Optional feature macro: IO_STATS_EN adds saturating rd_count/wr_count counters
// (and the CNT_W parameter that sizes them).
module io_port_bridge #(
  parameter int DEPTH_LOG2 = 3
`ifdef IO_STATS_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [7:0]            host_in_data,
  input  logic                  host_in_valid,
  output logic                  host_in_ready,
  output logic [7:0]            I,
  input  logic                  IEnable,
  input  logic [7:0]            O,
  input  logic                  OEnable,
  output logic [7:0]            host_out_data,
  output logic                  host_out_valid,
  input  logic                  host_out_ready,
  output logic [DEPTH_LOG2:0]   in_level,
  output logic [DEPTH_LOG2:0]   out_level,
  output logic                  underflow,
  output logic                  overflow,
  input  logic                  clr_flags
`ifdef IO_STATS_EN
  ,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      wr_count
`endif
);

  localparam int                  DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

  // ---------------- input FIFO (host -> CPU) ----------------
  logic [7:0]            in_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] in_wr_ptr, in_rd_ptr;
  logic                  in_empty, in_push, in_pop;

  assign in_empty      = (in_level == '0);
  // Ready is deasserted when full, so a pop on a full FIFO never admits a byte the same cycle.
  assign host_in_ready = !res && (in_level != FULL);
  assign in_push       = host_in_valid && host_in_ready;
  assign in_pop        = IEnable && !in_empty;
  assign I             = in_empty ? 8'h00 : in_mem[in_rd_ptr];

  // Input FIFO storage write.
  // NOTE: storage arrays carry no reset; the level counter alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_ptr] <= host_in_data;
  end

  // Input FIFO pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (res) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_level  <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
      if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
      case ({in_push, in_pop})
        2'b10:   in_level <= in_level + 1'b1;
        2'b01:   in_level <= in_level - 1'b1;
        default: in_level <= in_level;
      endcase
    end
  end

  // ---------------- output FIFO (CPU -> host) ----------------
  logic [7:0]            out_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] out_wr_ptr, out_rd_ptr;
  logic                  out_full, out_push, out_pop;

  // Full is judged on the pre-edge level: a host pop on the same edge does not make room.
  assign out_full       = (out_level == FULL);
  assign out_push       = OEnable && !out_full;
  assign host_out_valid = (out_level != '0);
  assign out_pop        = host_out_valid && host_out_ready;
  assign host_out_data  = out_mem[out_rd_ptr];

  // Output FIFO storage write.
  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr_ptr] <= O;
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (res) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_level  <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
      case ({out_push, out_pop})
        2'b10:   out_level <= out_level + 1'b1;
        2'b01:   out_level <= out_level - 1'b1;
        default: out_level <= out_level;
      endcase
    end
  end

  // Sticky error flags; a new error on the clearing edge keeps the flag set.
  always_ff @(posedge clk) begin
    if (res) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      underflow <= (underflow && !clr_flags) || (IEnable && in_empty);
      overflow  <= (overflow  && !clr_flags) || (OEnable && out_full);
    end
  end

`ifdef IO_STATS_EN
  // Saturating transfer counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (res) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (in_pop   && (rd_count != '1)) rd_count <= rd_count + 1'b1;
      if (out_push && (wr_count != '1)) wr_count <= wr_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_io_port_bridge.sv
// tb_io_port_bridge: directed self-checking bench for io_port_bridge.
// Inputs change 1 ns after each rising edge; outputs are compared there too.
module tb_io_port_bridge;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [7:0] host_in_data = 8'h00;
  logic       host_in_valid = 1'b0;
  logic       host_in_ready;
  logic [7:0] I;
  logic       IEnable = 1'b0;
  logic [7:0] O = 8'h00;
  logic       OEnable = 1'b0;
  logic [7:0] host_out_data;
  logic       host_out_valid;
  logic       host_out_ready = 1'b0;
  logic [3:0] in_level, out_level;
  logic       underflow, overflow;
  logic       clr_flags = 1'b0;
`ifdef IO_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  int checks = 0;
  int errors = 0;

  // Expected FIFO contents, used only for the streaming phase bookkeeping.
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  int exp_rd = 0;
  int exp_wr = 0;

  io_port_bridge dut (
    .clk            (clk),
    .res            (res),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .I              (I),
    .IEnable        (IEnable),
    .O              (O),
    .OEnable        (OEnable),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .in_level       (in_level),
    .out_level      (out_level),
    .underflow      (underflow),
    .overflow       (overflow),
    .clr_flags      (clr_flags)
`ifdef IO_STATS_EN
    ,
    .rd_count       (rd_count),
    .wr_count       (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock while tracking expected FIFO contents from the current inputs.
  task automatic step();
    bit ip, ipop, op, opop;
    ip   = host_in_valid && !res && (in_q.size() != 8);
    ipop = IEnable && (in_q.size() != 0);
    op   = OEnable && (out_q.size() != 8);
    opop = host_out_ready && (out_q.size() != 0);
    if (res) begin
      in_q.delete();
      out_q.delete();
      exp_rd = 0;
      exp_wr = 0;
    end else begin
      if (ipop) begin void'(in_q.pop_front()); exp_rd++; end
      if (ip) in_q.push_back(host_in_data);
      if (opop) void'(out_q.pop_front());
      if (op) begin out_q.push_back(O); exp_wr++; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int in_sent, in_got, out_sent, out_got;

    // ---- reset ----
    step();
    check("rst_ready_low", host_in_ready, 0);
    res = 1'b0;
    step();
    check("rst_ready_high", host_in_ready, 1);
    check("rst_I", I, 8'h00);
    check("rst_in_level", in_level, 0);
    check("rst_out_level", out_level, 0);
    check("rst_out_valid", host_out_valid, 0);
    check("rst_flags", {underflow, overflow}, 0);

    // ---- two pushes then one pop ----
    host_in_valid = 1'b1; host_in_data = 8'h11;
    step();
    check("push1_I", I, 8'h11);
    host_in_data = 8'h22;
    step();
    host_in_valid = 1'b0;
    check("push2_I", I, 8'h11);
    check("push2_level", in_level, 2);
    IEnable = 1'b1;
    step();
    check("pop1_I", I, 8'h22);
    check("pop1_level", in_level, 1);
    step();
    IEnable = 1'b0;
    check("pop2_level", in_level, 0);
    check("pop2_no_underflow", underflow, 0);

    // ---- fill to full, reject 9th, pop while full ----
    host_in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      host_in_data = 8'h30 + 8'(k);
      step();
    end
    check("full_level", in_level, 8);
    check("full_ready", host_in_ready, 0);
    host_in_data = 8'hFF;
    step();
    check("ninth_rejected", in_level, 8);
    IEnable = 1'b1;
    check("full_pop_ready", host_in_ready, 0);
    step();
    IEnable = 1'b0; host_in_valid = 1'b0;
    check("after_full_pop_level", in_level, 7);
    check("after_full_pop_ready", host_in_ready, 1);
    for (int k = 0; k < 7; k++) begin
      check("drain_in_I", I, 8'h31 + 8'(k));
      IEnable = 1'b1;
      step();
    end
    IEnable = 1'b0;
    check("drain_in_level", in_level, 0);

    // ---- underflow, clear, set-wins ----
    IEnable = 1'b1;
    step();
    IEnable = 1'b0;
    check("uf_flag", underflow, 1);
    check("uf_I", I, 8'h00);
    check("uf_level", in_level, 0);
    clr_flags = 1'b1; IEnable = 1'b1;
    step();
    check("uf_set_wins", underflow, 1);
    IEnable = 1'b0;
    step();
    clr_flags = 1'b0;
    check("uf_cleared", underflow, 0);
    host_in_valid = 1'b1; host_in_data = 8'h77; IEnable = 1'b1;
    step();
    host_in_valid = 1'b0; IEnable = 1'b0;
    check("empty_pushpop_level", in_level, 1);
    check("empty_pushpop_I", I, 8'h77);
    check("empty_pushpop_uf", underflow, 1);
    clr_flags = 1'b1; IEnable = 1'b1;
    step();
    clr_flags = 1'b0; IEnable = 1'b0;
    check("empty_pushpop_drain", in_level, 0);
    check("empty_pushpop_clr", underflow, 0);

    // ---- output FIFO fill / overflow ----
    OEnable = 1'b1; O = 8'hA5;
    step();
    OEnable = 1'b0;
    check("oen_valid", host_out_valid, 1);
    check("oen_data", host_out_data, 8'hA5);
    check("oen_level", out_level, 1);
    OEnable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      O = 8'hB0 + 8'(k);
      step();
    end
    OEnable = 1'b0;
    check("ovf_flag", overflow, 1);
    check("ovf_level", out_level, 8);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("ovf_cleared", overflow, 0);
    OEnable = 1'b1; O = 8'hEE; host_out_ready = 1'b1;
    step();
    OEnable = 1'b0; host_out_ready = 1'b0;
    check("full_oen_pop_level", out_level, 7);
    check("full_oen_pop_ovf", overflow, 1);
    for (int k = 0; k < 7; k++) begin
      check("drain_out_data", host_out_data, 8'hB0 + 8'(k));
      host_out_ready = 1'b1;
      step();
    end
    check("drain_out_valid", host_out_valid, 0);
    OEnable = 1'b1; O = 8'hC3;
    step();
    OEnable = 1'b0; host_out_ready = 1'b0;
    check("empty_oen_pop_valid", host_out_valid, 1);
    check("empty_oen_pop_data", host_out_data, 8'hC3);
    check("empty_oen_pop_level", out_level, 1);
    host_out_ready = 1'b1; clr_flags = 1'b1;
    step();
    host_out_ready = 1'b0; clr_flags = 1'b0;
    check("pre_stream_empty", {in_level, out_level}, 0);

`ifdef IO_STATS_EN
    check("stats_rd", rd_count, 16'(exp_rd));
    check("stats_wr", wr_count, 16'(exp_wr));
`endif

    // ---- stream 20 bytes each way with random gaps ----
    in_sent = 0; in_got = 0; out_sent = 0; out_got = 0;
    for (int cyc = 0; cyc < 1000 && !(in_got == 20 && out_got == 20); cyc++) begin
      host_in_valid  = (in_sent < 20) && ($urandom_range(0, 3) != 0);
      host_in_data   = 8'h40 + 8'(in_sent);
      IEnable        = (in_q.size() != 0) && ($urandom_range(0, 2) != 0);
      OEnable        = (out_sent < 20) && (out_q.size() != 8) && ($urandom_range(0, 3) != 0);
      O              = 8'h80 + 8'(out_sent);
      host_out_ready = ($urandom_range(0, 2) != 0);
      if (IEnable) begin
        check("stream_I", I, 8'h40 + 8'(in_got));
        in_got++;
      end
      if (host_out_ready && out_q.size() != 0) begin
        check("stream_out_data", host_out_data, 8'h80 + 8'(out_got));
        out_got++;
      end
      if (host_in_valid && in_q.size() != 8) in_sent++;
      if (OEnable) out_sent++;
      step();
      check("stream_in_level", in_level, in_q.size());
      check("stream_out_level", out_level, out_q.size());
    end
    host_in_valid = 1'b0; IEnable = 1'b0; OEnable = 1'b0; host_out_ready = 1'b0;
    check("stream_done", (in_got == 20) && (out_got == 20), 1);
    check("stream_flags", {underflow, overflow}, 0);

    // ---- reset with both FIFOs half full ----
    host_in_valid = 1'b1; OEnable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      host_in_data = 8'h60 + 8'(k);
      O = 8'h90 + 8'(k);
      step();
    end
    host_in_valid = 1'b0; OEnable = 1'b0;
    check("half_in_level", in_level, 4);
    check("half_out_level", out_level, 4);
    res = 1'b1;
    step();
    check("midrst_ready", host_in_ready, 0);
    res = 1'b0;
    check("midrst_in_level", in_level, 0);
    check("midrst_out_level", out_level, 0);
    check("midrst_I", I, 8'h00);
    check("midrst_valid", host_out_valid, 0);
`ifdef IO_STATS_EN
    check("midrst_rd_count", rd_count, 0);
    check("midrst_wr_count", wr_count, 0);
`endif
    step();
    check("post_rst_ready", host_in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
